// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: responder for the exec-stage UART request handshake.
// Write requests land in a TX FIFO that feeds the byte serializer; bytes from
// the deserializer land in an RX FIFO that read requests drain. A completion
// pulse is held back while the TX FIFO is full (write) or the RX FIFO is
// empty (read), which stalls exec until space or data appears.
module uart_io_ctrl #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             uart_wenable,
  input  logic [31:0]      uart_wd,
  output logic             uart_wdone,
  input  logic             uart_renable,
  output logic             uart_rdone,
  output logic [31:0]      uart_rd,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             err_clr,
  output logic             rx_overrun,
  output logic             proto_err,
  output logic [TX_AW:0]   tx_count,
  output logic [RX_AW:0]   rx_count
);

  localparam logic [TX_AW:0] TX_DEPTH = (TX_AW+1)'(2**TX_AW);
  localparam logic [RX_AW:0] RX_DEPTH = (RX_AW+1)'(2**RX_AW);

  typedef enum logic {W_IDLE, W_FULL} wstate_t;
  typedef enum logic {R_IDLE, R_EMPTY} rstate_t;

  // Only the low byte of a write carries data.
  logic unused_wd_hi;
  assign unused_wd_hi = ^uart_wd[31:8];

  // ---------------- TX side ----------------
  logic [7:0]       tx_mem_q [2**TX_AW];
  logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_AW:0]   tx_count_q, tx_count_d;
  logic             tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]       tx_push_data;
  wstate_t          wstate_q, wstate_d;
  logic [7:0]       wbuf_q, wbuf_d;
  logic             wdone_q, wdone_d;
  logic             proto_w;

  assign tx_full  = (tx_count_q == TX_DEPTH);
  assign tx_empty = (tx_count_q == '0);
  assign tx_pop   = !tx_empty && tx_ready;

  // Write FSM: push immediately when there is room, otherwise park the byte
  // and push it on the first edge the registered count shows space.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    wstate_d     = wstate_q;
    wbuf_d       = wbuf_q;
    tx_push      = 1'b0;
    tx_push_data = uart_wd[7:0];
    proto_w      = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (uart_wenable) begin
          if (!tx_full) begin
            tx_push = 1'b1;
          end else begin
            wbuf_d   = uart_wd[7:0];
            wstate_d = W_FULL;
          end
        end
      end
      W_FULL: begin
        proto_w = uart_wenable;
        if (!tx_full) begin
          tx_push      = 1'b1;
          tx_push_data = wbuf_q;
          wstate_d     = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    wdone_d = tx_push;
  end

  // TX FIFO pointer and occupancy update.
  always_comb begin
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TX_AW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + TX_AW'(1) : tx_rd_ptr_q;
    tx_count_d  = tx_count_q + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
  end

  // TX FIFO storage write.
  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_push_data;
  end

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];

  // ---------------- RX side ----------------
  logic [7:0]       rx_mem_q [2**RX_AW];
  logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_AW:0]   rx_count_q, rx_count_d;
  logic             rx_full, rx_empty, rx_push, rx_pop, rx_drop;
  rstate_t          rstate_q, rstate_d;
  logic [7:0]       rd_q, rd_d;
  logic             rdone_q, rdone_d;
  logic             proto_r;

  assign rx_full  = (rx_count_q == RX_DEPTH);
  assign rx_empty = (rx_count_q == '0);
  // A pop on the same edge does not rescue a byte arriving into a full FIFO.
  assign rx_push  = rx_valid && !rx_full;
  assign rx_drop  = rx_valid && rx_full;

  // Read FSM: pop immediately when data is present, otherwise wait in
  // R_EMPTY until the registered count shows a byte.
  always_comb begin
    rstate_d = rstate_q;
    rx_pop   = 1'b0;
    proto_r  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (uart_renable) begin
          if (!rx_empty) rx_pop = 1'b1;
          else           rstate_d = R_EMPTY;
        end
      end
      R_EMPTY: begin
        proto_r = uart_renable;
        if (!rx_empty) begin
          rx_pop   = 1'b1;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    rdone_d = rx_pop;
    rd_d    = rx_pop ? rx_mem_q[rx_rd_ptr_q] : rd_q;
  end

  // RX FIFO pointer and occupancy update.
  always_comb begin
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RX_AW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RX_AW'(1) : rx_rd_ptr_q;
    rx_count_d  = rx_count_q + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
  end

  // RX FIFO storage write.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data;
  end

  // ---------------- sticky errors ----------------
  logic rx_overrun_q, rx_overrun_d;
  logic proto_err_q, proto_err_d;

  // Clearing wins over a same-cycle error so software never loses the clear.
  always_comb begin
    rx_overrun_d = err_clr ? 1'b0 : (rx_overrun_q | rx_drop);
    proto_err_d  = err_clr ? 1'b0 : (proto_err_q | proto_w | proto_r);
  end

  // State registers for both paths and the error flags.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      wstate_q     <= W_IDLE;
      wbuf_q       <= '0;
      wdone_q      <= 1'b0;
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_count_q   <= '0;
      rstate_q     <= R_IDLE;
      rd_q         <= '0;
      rdone_q      <= 1'b0;
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_count_q   <= '0;
      rx_overrun_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      wstate_q     <= wstate_d;
      wbuf_q       <= wbuf_d;
      wdone_q      <= wdone_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_count_q   <= tx_count_d;
      rstate_q     <= rstate_d;
      rd_q         <= rd_d;
      rdone_q      <= rdone_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_count_q   <= rx_count_d;
      rx_overrun_q <= rx_overrun_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign uart_wdone = wdone_q;
  assign uart_rdone = rdone_q;
  assign uart_rd    = {24'h0, rd_q};
  assign rx_overrun = rx_overrun_q;
  assign proto_err  = proto_err_q;
  assign tx_count   = tx_count_q;
  assign rx_count   = rx_count_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl: write/read handshakes, FIFO full/empty
// stalls, overrun, protocol errors, simultaneous requests and async reset.
module tb_uart_io_ctrl;

  logic        clk, rstn;
  logic        uart_wenable, uart_renable, tx_ready, rx_valid, err_clr;
  logic [31:0] uart_wd;
  logic [7:0]  rx_data;
  logic        uart_wdone, uart_rdone, tx_valid, rx_overrun, proto_err;
  logic [31:0] uart_rd;
  logic [7:0]  tx_data;
  logic [4:0]  tx_count, rx_count;

  int n_cmp = 0;
  int n_err = 0;

  uart_io_ctrl #(.TX_AW(4), .RX_AW(4)) dut (
    .clk(clk), .rstn(rstn),
    .uart_wenable(uart_wenable), .uart_wd(uart_wd), .uart_wdone(uart_wdone),
    .uart_renable(uart_renable), .uart_rdone(uart_rdone), .uart_rd(uart_rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .err_clr(err_clr),
    .rx_overrun(rx_overrun), .proto_err(proto_err),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] got [32];
  int n_got, n_done, done_at, n_bad;

  initial begin
    rstn = 1'b0; uart_wenable = 1'b0; uart_renable = 1'b0; uart_wd = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; err_clr = 1'b0;

    // Reset state
    #3;
    check("rst_wdone", uart_wdone, 0);
    check("rst_rdone", uart_rdone, 0);
    check("rst_rd", uart_rd, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_counts", {tx_count, rx_count}, 0);
    check("rst_errs", {rx_overrun, proto_err}, 0);
    step(); step();
    rstn = 1'b1;
    step();

    // 1: single write, drained straight away
    tx_ready = 1'b1; uart_wenable = 1'b1; uart_wd = 32'h1234_5641;
    step();
    uart_wenable = 1'b0;
    check("t1_wdone", uart_wdone, 1);
    check("t1_tx_valid", tx_valid, 1);
    check("t1_tx_data", tx_data, 8'h41);
    check("t1_tx_count1", tx_count, 1);
    step();
    check("t1_wdone_gone", uart_wdone, 0);
    check("t1_tx_count0", tx_count, 0);
    check("t1_tx_empty", tx_valid, 0);

    // 2: fill TX, stall the 17th write, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      uart_wenable = 1'b1; uart_wd = 32'hFFFF_FF10 + i;
      step();
      uart_wenable = 1'b0;
      check("t2_fill_wdone", uart_wdone, 1);
    end
    check("t2_tx_count16", tx_count, 16);
    uart_wenable = 1'b1; uart_wd = 32'h0000_005A;
    step();
    uart_wenable = 1'b0;
    check("t2_full_no_wdone", uart_wdone, 0);
    check("t2_full_count", tx_count, 16);
    step();
    check("t2_still_stalled", uart_wdone, 0);
    uart_wenable = 1'b1; uart_wd = 32'h0000_00EE;
    step();
    uart_wenable = 1'b0;
    check("t2_proto_err_w", proto_err, 1);
    check("t2_ignored_no_wdone", uart_wdone, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t2_proto_clr", proto_err, 0);
    tx_ready = 1'b1; n_got = 0; n_done = 0; done_at = -1;
    for (int k = 0; k < 22; k++) begin
      if (tx_valid && n_got < 32) begin
        got[n_got] = tx_data;
        n_got++;
      end
      step();
      if (uart_wdone) begin
        n_done++;
        done_at = k;
      end
    end
    check("t2_drain_count", n_got, 17);
    check("t2_first_byte", got[0], 8'h10);
    check("t2_16th_byte", got[15], 8'h1F);
    check("t2_last_byte", got[16], 8'h5A);
    check("t2_wdone_once", n_done, 1);
    check("t2_wdone_after_pop", done_at, 1);
    check("t2_tx_empty", tx_count, 0);

    // 3: read waits on empty RX
    uart_renable = 1'b1;
    step();
    uart_renable = 1'b0;
    check("t3_no_rdone", uart_rdone, 0);
    step(); step(); step(); step();
    check("t3_waiting", uart_rdone, 0);
    rx_valid = 1'b1; rx_data = 8'hC3;
    step();
    rx_valid = 1'b0;
    check("t3_rdone_not_yet", uart_rdone, 0);
    check("t3_rx_count1", rx_count, 1);
    step();
    check("t3_rdone", uart_rdone, 1);
    check("t3_rd", uart_rd, 32'h0000_00C3);
    check("t3_rx_count0", rx_count, 0);
    step();
    check("t3_rdone_pulse", uart_rdone, 0);
    check("t3_rd_hold", uart_rd, 32'h0000_00C3);

    // 4: overrun and drain
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1'b1; rx_data = 8'h20 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    check("t4_rx_count16", rx_count, 16);
    check("t4_overrun", rx_overrun, 1);
    err_clr = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    step();
    err_clr = 1'b0; rx_valid = 1'b0;
    check("t4_clr_priority", rx_overrun, 0);
    check("t4_count_kept", rx_count, 16);
    for (int i = 0; i < 16; i++) begin
      uart_renable = 1'b1;
      step();
      uart_renable = 1'b0;
      check("t4_rdone", uart_rdone, 1);
      check("t4_rd", uart_rd, 32'h20 + i);
    end
    check("t4_rx_empty", rx_count, 0);
    check("t4_no_proto", proto_err, 0);

    // 5: simultaneous write and read
    rx_valid = 1'b1; rx_data = 8'h07;
    step();
    rx_valid = 1'b0;
    uart_wenable = 1'b1; uart_wd = 32'hFFFF_FF33; uart_renable = 1'b1;
    step();
    uart_wenable = 1'b0; uart_renable = 1'b0;
    check("t5_both_done", {uart_wdone, uart_rdone}, 2'b11);
    check("t5_rd", uart_rd, 32'h0000_0007);
    step();
    check("t5_done_pulse", {uart_wdone, uart_rdone}, 2'b00);
    check("t5_tx_drained", tx_count, 0);

    // 6: proto error on read, then reset mid-WFULL
    tx_ready = 1'b0; uart_wenable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      uart_wd = 32'h0 + i;
      step();
    end
    uart_wd = 32'h5A;
    step();
    uart_wenable = 1'b0;
    check("t6_wfull_no_wdone", uart_wdone, 0);
    check("t6_tx_count16", tx_count, 16);
    uart_renable = 1'b1;
    step();
    check("t6_first_rd_no_err", proto_err, 0);
    step();
    uart_renable = 1'b0;
    check("t6_proto_err_r", proto_err, 1);
    check("t6_no_rdone", uart_rdone, 0);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_counts", {tx_count, rx_count}, 0);
    check("t6_rst_errs", {rx_overrun, proto_err}, 0);
    tx_ready = 1'b1;
    step();
    rstn = 1'b1;
    n_bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (uart_wdone || uart_rdone || tx_valid) n_bad++;
    end
    check("t6_pending_dropped", n_bad, 0);
    check("t6_tx_count_after", tx_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
